// File: rtl/ub_pkg.sv
// Shared defaults, types and helpers for the unified-buffer block family.
package ub_pkg;

   localparam int UB_DATA_W = 16;
   localparam int UB_CNT_W  = 16;

   typedef logic [UB_DATA_W-1:0] data_t;
   typedef logic [UB_CNT_W-1:0]  cnt_t;

   // A zero extent describes a degenerate loop that still runs once.
   function automatic cnt_t clamp_extent(input cnt_t ext);
      return (ext == '0) ? cnt_t'(1) : ext;
   endfunction

endpackage

// File: rtl/ub_iter_counter.sv
// DIMS-deep carry-chain iteration counter; index 0 is innermost.
// Pulses done for one cycle after the step that completes the whole domain.
module ub_iter_counter
   import ub_pkg::*;
#(
   parameter int DIMS  = 3,
   parameter int CNT_W = UB_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  step,
   input  logic [DIMS*CNT_W-1:0] extent,
   output logic [DIMS*CNT_W-1:0] count,
   output logic                  done
);

   logic [CNT_W-1:0] cnt_q [DIMS];
   logic [CNT_W-1:0] cnt_d [DIMS];
   logic             done_q;
   logic             done_d;
   logic             carry;
   logic [CNT_W-1:0] last;
   logic [CNT_W-1:0] ext;

   always_comb begin
      carry = step;
      last  = '0;
      ext   = '0;
      for (int unsigned d = 0; d < DIMS; d++) begin
         ext      = extent[d*CNT_W +: CNT_W];
         last     = (ext == '0) ? '0 : ext - CNT_W'(1);
         cnt_d[d] = cnt_q[d];
         if (carry) begin
            if (cnt_q[d] == last) begin
               cnt_d[d] = '0;
            end else begin
               cnt_d[d] = cnt_q[d] + CNT_W'(1);
               carry    = 1'b0;
            end
         end
      end
      // A carry that survives the outermost dimension marks the final iteration.
      done_d = carry;
      if (flush) begin
         for (int unsigned d = 0; d < DIMS; d++) begin
            cnt_d[d] = '0;
         end
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned d = 0; d < DIMS; d++) begin
            cnt_q[d] <= '0;
         end
         done_q <= 1'b0;
      end else begin
         for (int unsigned d = 0; d < DIMS; d++) begin
            cnt_q[d] <= cnt_d[d];
         end
         done_q <= done_d;
      end
   end

   always_comb begin
      count = '0;
      for (int unsigned d = 0; d < DIMS; d++) begin
         count[d*CNT_W +: CNT_W] = cnt_q[d];
      end
   end

   assign done = done_q;

endmodule

// File: rtl/ub_stencil_delay_buffer.sv
// Circular delay buffer with NUM_TAPS run-time delayed read taps and a
// built-in write iteration counter that supplies ctrl_vars/done.
module ub_stencil_delay_buffer
   import ub_pkg::*;
#(
   parameter  int DATA_W   = UB_DATA_W,
   parameter  int DEPTH    = 64,
   parameter  int NUM_TAPS = 4,
   parameter  int DIMS     = 3,
   parameter  int CNT_W    = UB_CNT_W,
   localparam int PTR_W    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [DIMS*CNT_W-1:0]     cfg_extent,
   input  logic [NUM_TAPS*PTR_W-1:0] cfg_tap_delay,
   input  logic                      wen,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      ren,
   output logic [NUM_TAPS*DATA_W-1:0] rdata,
   output logic [NUM_TAPS-1:0]       rvalid,
   output logic [DIMS*CNT_W-1:0]     ctrl_vars,
   output logic                      done
);

   localparam logic [PTR_W:0] FILL_MAX = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W:0]    fill_q, fill_d;
   logic [DATA_W-1:0] rdata_q [NUM_TAPS];
   logic [DATA_W-1:0] rdata_d [NUM_TAPS];
   logic [NUM_TAPS-1:0] rvalid_q, rvalid_d;
   logic [PTR_W-1:0]  delay;
   logic [PTR_W-1:0]  rd_addr;
   logic              wr_en;
   logic              rd_en;

   assign wr_en = wen & ~flush;
   assign rd_en = ren & ~flush;

   always_comb begin
      wptr_d = wptr_q;
      fill_d = fill_q;
      if (flush) begin
         wptr_d = '0;
         fill_d = '0;
      end else if (wen) begin
         wptr_d = wptr_q + PTR_W'(1);
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + (PTR_W+1)'(1);
         end
      end
   end

   // Reads use the pre-write pointer/fill, so a same-cycle write is never visible.
   always_comb begin
      delay   = '0;
      rd_addr = '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
         delay       = cfg_tap_delay[k*PTR_W +: PTR_W];
         rd_addr     = wptr_q - PTR_W'(1) - delay;
         rdata_d[k]  = rdata_q[k];
         rvalid_d[k] = 1'b0;
         if (rd_en) begin
            rdata_d[k]  = mem_q[rd_addr];
            rvalid_d[k] = (fill_q > {1'b0, delay});
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         fill_q   <= '0;
         rvalid_q <= '0;
         for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            rdata_q[k] <= '0;
         end
      end else begin
         wptr_q   <= wptr_d;
         fill_q   <= fill_d;
         rvalid_q <= rvalid_d;
         for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            rdata_q[k] <= rdata_d[k];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
         rdata[k*DATA_W +: DATA_W] = rdata_q[k];
      end
   end

   assign rvalid = rvalid_q;

   ub_iter_counter #(
      .DIMS  (DIMS),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .step   (wen),
      .extent (cfg_extent),
      .count  (ctrl_vars),
      .done   (done)
   );

endmodule

// File: tb/tb_ub_stencil_delay_buffer.sv
// Directed bench for ub_stencil_delay_buffer with hand-computed expectations.
module tb_ub_stencil_delay_buffer;

   localparam int DW = 16;
   localparam int NT = 4;
   localparam int PW = 6;
   localparam int DM = 3;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic [DM*CW-1:0]  cfg_extent;
   logic [NT*PW-1:0]  cfg_tap_delay;
   logic              wen = 1'b0;
   logic [DW-1:0]     wdata = '0;
   logic              ren = 1'b0;
   logic [NT*DW-1:0]  rdata;
   logic [NT-1:0]     rvalid;
   logic [DM*CW-1:0]  ctrl_vars;
   logic              done;

   int n_chk = 0;
   int n_bad = 0;
   int pulses;

   ub_stencil_delay_buffer #(
      .DATA_W   (DW),
      .DEPTH    (64),
      .NUM_TAPS (NT),
      .DIMS     (DM),
      .CNT_W    (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .cfg_extent    (cfg_extent),
      .cfg_tap_delay (cfg_tap_delay),
      .wen           (wen),
      .wdata         (wdata),
      .ren           (ren),
      .rdata         (rdata),
      .rvalid        (rvalid),
      .ctrl_vars     (ctrl_vars),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] tap(input int k);
      return rdata[k*DW +: DW];
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int v);
      wen   = 1'b1;
      wdata = DW'(v);
      step;
      wen   = 1'b0;
   endtask

   task automatic rd;
      ren = 1'b1;
      step;
      ren = 1'b0;
   endtask

   task automatic do_flush;
      flush = 1'b1;
      step;
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_extent    = {16'd3, 16'd2, 16'd4};
      cfg_tap_delay = {6'd63, 6'd5, 6'd1, 6'd0};
      repeat (2) step;
      rst = 1'b0;
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_ctrl", 64'(ctrl_vars), 64'd0);
      check("rst_done", 64'(done), 64'd0);

      // reset mid-stream
      for (int i = 0; i < 10; i++) wr(100 + i);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_rdata", rdata, 64'd0);
      check("mid_rst_rvalid", 64'(rvalid), 64'd0);
      check("mid_rst_ctrl", 64'(ctrl_vars), 64'd0);
      rd;
      check("mid_rst_rd_valid", 64'(rvalid), 64'd0);
      wr(55);
      rd;
      check("mid_rst_first_wr", 64'(tap(0)), 64'd55);
      check("mid_rst_first_valid", 64'(rvalid), 64'b0001);

      // tap delays over a wrapped buffer
      do_flush;
      for (int i = 0; i < 100; i++) wr(i);
      rd;
      check("tap0", 64'(tap(0)), 64'd99);
      check("tap1", 64'(tap(1)), 64'd98);
      check("tap2", 64'(tap(2)), 64'd94);
      check("tap3", 64'(tap(3)), 64'd36);
      check("tap_valid", 64'(rvalid), 64'hF);
      step;
      check("tap_valid_drop", 64'(rvalid), 64'd0);
      check("tap_hold", 64'(tap(0)), 64'd99);

      // fill gating
      do_flush;
      wr(10); wr(11); wr(12);
      rd;
      check("fill_tap0", 64'(tap(0)), 64'd12);
      check("fill_tap1", 64'(tap(1)), 64'd11);
      check("fill_valid", 64'(rvalid), 64'b0011);

      // simultaneous read and write
      do_flush;
      for (int i = 0; i < 4; i++) wr(i);
      wen = 1'b1; wdata = 16'd77; ren = 1'b1;
      step;
      wen = 1'b0; ren = 1'b0;
      check("rw_same_cycle", 64'(tap(0)), 64'd3);
      rd;
      check("rw_next_read", 64'(tap(0)), 64'd77);

      // iteration counter, extents {4,2,3}
      cfg_extent = {16'd3, 16'd2, 16'd4};
      do_flush;
      check("iter_start", 64'(ctrl_vars), 64'd0);
      pulses = 0;
      for (int n = 1; n <= 24; n++) begin
         wr(n);
         check("iter_cv", 64'(ctrl_vars), 64'({16'(n / 8 % 3), 16'(n / 4 % 2), 16'(n % 4)}));
         check("iter_done", 64'(done), 64'(n == 24));
         if (done) pulses++;
      end
      step;
      if (done) pulses++;
      check("iter_pulses", 64'(pulses), 64'd1);

      // extent[1]=0 behaves as 1
      cfg_extent = {16'd3, 16'd0, 16'd4};
      do_flush;
      pulses = 0;
      for (int n = 1; n <= 12; n++) begin
         wr(n);
         check("iter0_cv", 64'(ctrl_vars), 64'({16'(n / 4 % 3), 16'd0, 16'(n % 4)}));
         check("iter0_done", 64'(done), 64'(n == 12));
         if (done) pulses++;
      end
      step;
      if (done) pulses++;
      check("iter0_pulses", 64'(pulses), 64'd1);

      // flush priority over wen/ren
      cfg_extent = {16'd3, 16'd2, 16'd4};
      do_flush;
      for (int i = 0; i < 20; i++) wr(200 + i);
      rd;
      check("fl_pre_tap0", 64'(tap(0)), 64'd219);
      flush = 1'b1; wen = 1'b1; wdata = 16'd999; ren = 1'b1;
      step;
      flush = 1'b0; wen = 1'b0; ren = 1'b0;
      check("fl_rvalid", 64'(rvalid), 64'd0);
      check("fl_rdata_hold", 64'(tap(0)), 64'd219);
      check("fl_ctrl", 64'(ctrl_vars), 64'd0);
      check("fl_done", 64'(done), 64'd0);
      rd;
      check("fl_fill_zero", 64'(rvalid), 64'd0);
      wr(555);
      rd;
      check("fl_next_wr", 64'(tap(0)), 64'd555);
      check("fl_next_valid", 64'(rvalid), 64'b0001);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ub_stencil_delay_buffer.md
Name: ub_stencil_delay_buffer

Overview:
- Parametrised successor to the per-edge depth-1 unified-buffer delay shift registers.
- One circular storage array serves NUM_TAPS read taps. Each tap has a run-time-configured delay, counted in accepted writes.
- Carries its own multi-dimensional write iteration counter, so the block generates its ctrl_vars and no external loop nest is needed.
- Sits between a producer compute op and one or more consumer stencil ops inside a *_ub wrapper.

Parameters:
- DATA_W, 16, data word width.
- DEPTH, 64, storage entries; must be a power of 2 and at least 2.
- NUM_TAPS, 4, number of independent read taps.
- DIMS, 3, iteration-domain dimensions; index 0 is innermost.
- CNT_W, 16, width of each iteration counter and extent.
- PTR_W, $clog2(DEPTH), derived; not overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers, fill count, counters and valids.
- cfg_extent  in  DIMS x CNT_W  loop extent per dimension; value 0 is treated as 1.
- cfg_tap_delay  in  NUM_TAPS x PTR_W  delay of each tap, 0..DEPTH-1.
- wen  in  1  write strobe.
- wdata  in  DATA_W  write data.
- ren  in  1  read strobe, applies to all taps.
- rdata  out  NUM_TAPS x DATA_W  registered tap data.
- rvalid  out  NUM_TAPS  per-tap valid for rdata.
- ctrl_vars  out  DIMS x CNT_W  iteration index of the next write.
- done  out  1  one-cycle pulse after the final iteration's write.

Behaviour:
- Reset (rst high, asynchronous):
  - wptr, fill, ctrl_vars, rdata, rvalid and done all go to 0.
  - Storage contents are not reset.
- Write, when wen=1:
  - storage[wptr] <= wdata.
  - wptr <= wptr+1, wrapping modulo DEPTH.
  - fill <= min(fill+1, DEPTH); fill is PTR_W+1 bits and saturates.
  - Older data is overwritten silently. There is no full stall.
- Read, when ren=1:
  - For each tap k: rdata[k] <= storage[(wptr-1-cfg_tap_delay[k]) mod DEPTH], i.e. the sample written delay_k writes before the most recent one.
  - rvalid[k] <= (fill > cfg_tap_delay[k]).
  - Latency is 1 cycle from ren to rdata/rvalid.
- ren=0: rvalid <= 0 and rdata holds its previous value.
- wen and ren in the same cycle: the read uses the pre-write wptr and fill, so it never sees that cycle's wdata.
- Iteration counter: advances only on wen.
  - ctrl_vars[0] increments each write.
  - When ctrl_vars[d] == extent[d]-1 it wraps to 0 and carries into d+1.
  - When every dimension is at extent-1 and wen=1: done <= 1 for one cycle and all counters wrap to 0.
  - With no carry, done <= 0.
- flush, when flush=1:
  - Same-cycle wen/ren are ignored.
  - wptr, fill, ctrl_vars, rvalid and done go to 0 on the next edge.
  - rdata holds its value.
  - flush takes priority over wen and ren.
- Configuration inputs are sampled combinationally each cycle. Changing them mid-stream is legal and takes effect on the next read.
- Arithmetic: pointer subtraction is PTR_W-bit unsigned wrap-around. Extent compare uses CNT_W unsigned.

Decomposition:
- Package ub_pkg holds:
  - default DATA_W/CNT_W localparams;
  - typedef data_t (logic [DATA_W-1:0]);
  - typedef cnt_t;
  - function clamp_extent (0 maps to 1).
- Sub-module ub_iter_counter holds the DIMS-deep carry-chain counter with done generation. It is instantiated once and also reused by future address generators.

Test Plan:
- Reset mid-stream: write 10 words, assert rst for 1 cycle, then ren. Required: rvalid=0, rdata=0, ctrl_vars=0, and the next write lands at entry 0.
- Tap delays: DEPTH=64, delays {0,1,5,63}, write 0..99, then ren. Required:
  - rdata = {99,98,94,36}, all rvalid=1, one cycle later.
- Fill gating: write 3 words (10,11,12), delays {0,1,5,63}, ren. Required:
  - rdata[0]=12, rdata[1]=11;
  - rvalid = {1,1,0,0}.
- Simultaneous read/write: 4 words written (0..3), same cycle wen with wdata=77 and ren with delay 0. Required: rdata[0]=3; the next read with delay 0 gives 77.
- Iteration counter: extents {4,2,3}, 24 writes. Required:
  - ctrl_vars steps (0,0,0)→(3,0,0)→(0,1,0)…;
  - done pulses exactly once, on the edge after write 24;
  - ctrl_vars then reads (0,0,0).
  - Repeat with extent[1]=0: behaves as extent 1, done after 12 writes.
- Flush priority: after 20 writes, assert flush together with wen and ren. Required:
  - that write is dropped, rvalid=0, fill=0;
  - the following write goes to entry 0.
